// File: rtl/mem_wb_multi_pkg.sv
// Shared constants and types for the MEM/WB write-back boundary.
// Flow-control op encodings and register-file reset values live here.
package mem_wb_multi_pkg;

    localparam logic [1:0]  NORMAL_OP           = 2'b00;
    localparam logic [1:0]  RST_OP              = 2'b01;
    localparam logic [1:0]  KEEP_OP             = 2'b10;
    localparam logic [31:0] ZeroWord            = 32'h0000_0000;
    localparam logic [4:0]  DEFAULT_WriteRegDst = 5'd0;
    localparam logic        DEFAULT_RegWrite    = 1'b0;
    localparam logic [31:0] INS_NOP             = 32'h0000_0000;

    // Per-stage control decoded once in the top from the flow op.
    typedef enum logic [1:0] {
        STG_HOLD  = 2'd0,
        STG_LOAD  = 2'd1,
        STG_CLEAR = 2'd2
    } stage_ctl_e;

endpackage

// File: rtl/mem_wb_lane_stage.sv
// One MEM/WB register stage holding LANES write-back slots.
// Reset and CLEAR both load the bubble value; HOLD keeps the stage.
module mem_wb_lane_stage
    import mem_wb_multi_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LANES      = 1,
    parameter bit DEBUG_MODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  stage_ctl_e              i_ctl,
    input  logic [LANES*DATA_W-1:0] i_data,
    input  logic [LANES*ADDR_W-1:0] i_dst,
    input  logic [LANES-1:0]        i_we,
    input  logic [LANES*32-1:0]     i_ins,
    output logic [LANES*DATA_W-1:0] o_data,
    output logic [LANES*ADDR_W-1:0] o_dst,
    output logic [LANES-1:0]        o_we,
    output logic [LANES*32-1:0]     o_ins
);

    logic [LANES*DATA_W-1:0] r_data;
    logic [LANES*ADDR_W-1:0] r_dst;
    logic [LANES-1:0]        r_we;

    always_ff @(posedge clk) begin
        if (!rst || i_ctl == STG_CLEAR) begin
            r_data <= {LANES{DATA_W'(ZeroWord)}};
            r_dst  <= {LANES{ADDR_W'(DEFAULT_WriteRegDst)}};
            r_we   <= {LANES{DEFAULT_RegWrite}};
        end else if (i_ctl == STG_LOAD) begin
            r_data <= i_data;
            r_dst  <= i_dst;
            r_we   <= i_we;
        end
    end

    assign o_data = r_data;
    assign o_dst  = r_dst;
    assign o_we   = r_we;

    // Instruction tags are only carried in debug builds.
    generate
        if (DEBUG_MODE) begin : g_ins
            logic [LANES*32-1:0] r_ins;
            always_ff @(posedge clk) begin
                if (!rst || i_ctl == STG_CLEAR)
                    r_ins <= {LANES{INS_NOP}};
                else if (i_ctl == STG_LOAD)
                    r_ins <= i_ins;
            end
            assign o_ins = r_ins;
        end else begin : g_no_ins
            logic w_ins_unused;
            assign w_ins_unused = ^i_ins;
            assign o_ins        = {LANES{INS_NOP}};
        end
    endgenerate

endmodule

// File: rtl/mem_wb_multi.sv
// MEM/WB boundary: DEPTH-stage chain of LANES write-back slots feeding the
// register file, plus combinational forwarding lookup and retired-write count.
module mem_wb_multi
    import mem_wb_multi_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LANES      = 1,
    parameter int DEPTH      = 1,
    parameter int RD_PORTS   = 2,
    parameter int CNT_W      = 32,
    parameter bit DEBUG_MODE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 MemWbOp_i,
    input  logic [LANES*DATA_W-1:0]    WriteRegData_i,
    input  logic [LANES*ADDR_W-1:0]    WriteRegDst_i,
    input  logic [LANES-1:0]           RegWrite_i,
    output logic [LANES*DATA_W-1:0]    WriteRegData_o,
    output logic [LANES*ADDR_W-1:0]    WriteRegDst_o,
    output logic [LANES-1:0]           RegWrite_o,
    input  logic [RD_PORTS*ADDR_W-1:0] FwdAddr_i,
    output logic [RD_PORTS-1:0]        FwdHit_o,
    output logic [RD_PORTS*DATA_W-1:0] FwdData_o,
    output logic [CNT_W-1:0]           RetireCnt_o,
    input  logic [LANES*32-1:0]        ins_i,
    output logic [LANES*32-1:0]        ins_o
);

    logic [DEPTH-1:0][LANES*DATA_W-1:0] w_src_data, w_data;
    logic [DEPTH-1:0][LANES*ADDR_W-1:0] w_src_dst,  w_dst;
    logic [DEPTH-1:0][LANES-1:0]        w_src_we,   w_we;
    logic [DEPTH-1:0][LANES*32-1:0]     w_src_ins,  w_ins;
    stage_ctl_e                         w_ctl [DEPTH];
    logic                               w_advance;
    logic [CNT_W-1:0]                   w_pop;
    logic [CNT_W-1:0]                   r_cnt;

    assign w_advance = (MemWbOp_i == NORMAL_OP) || (MemWbOp_i == RST_OP);

    // RST_OP only injects a bubble at the entry; older stages keep draining.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            w_ctl[s] = STG_HOLD;
            if (MemWbOp_i == NORMAL_OP)
                w_ctl[s] = STG_LOAD;
            else if (MemWbOp_i == RST_OP)
                w_ctl[s] = (s == 0) ? STG_CLEAR : STG_LOAD;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign w_src_data[g] = WriteRegData_i;
                assign w_src_dst[g]  = WriteRegDst_i;
                assign w_src_we[g]   = RegWrite_i;
                assign w_src_ins[g]  = ins_i;
            end else begin : g_body
                assign w_src_data[g] = w_data[g-1];
                assign w_src_dst[g]  = w_dst[g-1];
                assign w_src_we[g]   = w_we[g-1];
                assign w_src_ins[g]  = w_ins[g-1];
            end

            mem_wb_lane_stage #(
                .DATA_W     (DATA_W),
                .ADDR_W     (ADDR_W),
                .LANES      (LANES),
                .DEBUG_MODE (DEBUG_MODE)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_ctl  (w_ctl[g]),
                .i_data (w_src_data[g]),
                .i_dst  (w_src_dst[g]),
                .i_we   (w_src_we[g]),
                .i_ins  (w_src_ins[g]),
                .o_data (w_data[g]),
                .o_dst  (w_dst[g]),
                .o_we   (w_we[g]),
                .o_ins  (w_ins[g])
            );
        end
    endgenerate

    assign WriteRegData_o = w_data[DEPTH-1];
    assign WriteRegDst_o  = w_dst[DEPTH-1];
    assign RegWrite_o     = w_we[DEPTH-1];
    assign ins_o          = w_ins[DEPTH-1];

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < LANES; l++)
            w_pop = w_pop + CNT_W'(w_we[DEPTH-1][l]);
    end

    // Counts the final-stage writes handed to the register file on this edge.
    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else if (w_advance)
            r_cnt <= r_cnt + w_pop;
    end

    assign RetireCnt_o = r_cnt;

    // Scan oldest to youngest so the last match (youngest stage, highest lane) wins.
    always_comb begin
        logic [ADDR_W-1:0] qa;
        FwdHit_o  = '0;
        FwdData_o = '0;
        qa        = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            qa = FwdAddr_i[p*ADDR_W +: ADDR_W];
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (w_we[s][l] && (qa != '0) &&
                        (w_dst[s][l*ADDR_W +: ADDR_W] == qa)) begin
                        FwdHit_o[p]                    = 1'b1;
                        FwdData_o[p*DATA_W +: DATA_W]  = w_data[s][l*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule
